cdb_arbiter: RTL and testbench

Common-data-bus arbiter and broadcaster for the out-of-order core. It collects completion results from the four functional units (ALU, LSU, MUL, BR), grants one per cycle by round-robin, and drives the registered CDB broadcast. The decode/rename stage, the reservation stations and the ROB consume that broadcast as `cdb_en`/`cdb_reg_addr`. It is the producing end of the CDB interface that decode consumes.

---
 rtl/cdb_arbiter_if.sv | 32 +++
 rtl/cdb_arbiter.sv | 101 ++++++++++
 tb/tb_cdb_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Completion-request and CDB-broadcast bundle between the functional units,
// the arbiter and the CDB consumers.
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic [3:0]          req_valid_i;
  logic [3:0]          req_ready_o;
  logic [19:0]         req_rd_i;
  logic [4*DATA_W-1:0] req_data_i;
  logic [4*TAG_W-1:0]  req_tag_i;

  logic                cdb_en_o;
  logic [4:0]          cdb_reg_addr_o;
  logic [DATA_W-1:0]   cdb_data_o;
  logic [TAG_W-1:0]    cdb_tag_o;
  logic [1:0]          cdb_src_o;

  // Arbiter side.
  modport master (
    input  req_valid_i, req_rd_i, req_data_i, req_tag_i,
    output req_ready_o,
    output cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_tag_o, cdb_src_o
  );

  // Functional-unit / consumer side.
  modport slave (
    output req_valid_i, req_rd_i, req_data_i, req_tag_i,
    input  req_ready_o,
    input  cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_tag_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter over four FU completion ports driving the registered
// common-data-bus broadcast (one result per cycle, one-cycle latency).
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  cdb_arbiter_if.master bus
);

  logic [1:0]        rr_ptr_q,   rr_ptr_d;
  logic              cdb_en_q,   cdb_en_d;
  logic [4:0]        cdb_rd_q,   cdb_rd_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]  cdb_tag_q,  cdb_tag_d;
  logic [1:0]        cdb_src_q,  cdb_src_d;

  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [1:0]        cand;
  logic              accept;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;

  // First valid source at or after the round-robin pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!gnt_any && bus.req_valid_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Holding reset_i low keeps every FU stalled while reset is asserted.
  assign accept          = gnt_any & ~flush_i & reset_i;
  assign bus.req_ready_o = accept ? (4'b0001 << gnt_idx) : '0;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_rd   = bus.req_rd_i[5*i +: 5];
        sel_data = bus.req_data_i[DATA_W*i +: DATA_W];
        sel_tag  = bus.req_tag_i[TAG_W*i +: TAG_W];
      end
    end
  end

  // Payload registers hold when idle; consumers qualify with cdb_en.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cdb_en_d   = 1'b0;
    cdb_rd_d   = cdb_rd_q;
    cdb_data_d = cdb_data_q;
    cdb_tag_d  = cdb_tag_q;
    cdb_src_d  = cdb_src_q;
    if (accept) begin
      rr_ptr_d   = gnt_idx + 2'd1;
      cdb_en_d   = 1'b1;
      cdb_rd_d   = sel_rd;
      cdb_data_d = sel_data;
      cdb_tag_d  = sel_tag;
      cdb_src_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_ptr_q   <= '0;
      cdb_en_q   <= 1'b0;
      cdb_rd_q   <= '0;
      cdb_data_q <= '0;
      cdb_tag_q  <= '0;
      cdb_src_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_rd_q   <= cdb_rd_d;
      cdb_data_q <= cdb_data_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  assign bus.cdb_en_o       = cdb_en_q;
  assign bus.cdb_reg_addr_o = cdb_rd_q;
  assign bus.cdb_data_o     = cdb_data_q;
  assign bus.cdb_tag_o      = cdb_tag_q;
  assign bus.cdb_src_o      = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued when a grant
// is expected and popped when the bus is sampled after the clock edge.
module tb_cdb_arbiter;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        src;
  } exp_t;

  logic clk_i;
  logic reset_i;
  logic flush_i;

  cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) ifc ();

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .bus     (ifc.master)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sbq[$];

  logic [4:0]        pl_rd   [4];
  logic [DATA_W-1:0] pl_data [4];
  logic [TAG_W-1:0]  pl_tag  [4];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic fl);
    ifc.req_valid_i = vld;
    flush_i         = fl;
    for (int i = 0; i < 4; i++) begin
      ifc.req_rd_i[5*i +: 5]            = pl_rd[i];
      ifc.req_data_i[DATA_W*i +: DATA_W] = pl_data[i];
      ifc.req_tag_i[TAG_W*i +: TAG_W]    = pl_tag[i];
    end
  endtask

  task automatic chk_zero_bus(input string tag);
    chk({tag, "_en"},   64'(ifc.cdb_en_o),       64'd0);
    chk({tag, "_rd"},   64'(ifc.cdb_reg_addr_o), 64'd0);
    chk({tag, "_data"}, 64'(ifc.cdb_data_o),     64'd0);
    chk({tag, "_tag"},  64'(ifc.cdb_tag_o),      64'd0);
    chk({tag, "_src"},  64'(ifc.cdb_src_o),      64'd0);
    chk({tag, "_rdy"},  64'(ifc.req_ready_o),    64'd0);
  endtask

  // One cycle: drive, check ready against the directed grant g (-1 = none),
  // clock, then compare the bus against the scoreboard.
  task automatic step(input string tag, input logic [3:0] vld, input logic fl, input int g);
    logic [3:0] er;
    exp_t       e;
    drive(vld, fl);
    #1;
    er = (g < 0) ? 4'b0000 : (4'b0001 << g);
    chk({tag, "_ready"}, 64'(ifc.req_ready_o), 64'(er));
    if (g >= 0) begin
      e.rd   = pl_rd[g];
      e.data = pl_data[g];
      e.tag  = pl_tag[g];
      e.src  = 2'(g);
      sbq.push_back(e);
    end
    @(posedge clk_i);
    #1;
    if (g >= 0) begin
      pl_rd[g]   = 5'($urandom_range(0, 31));
      pl_data[g] = $urandom;
      pl_tag[g]  = 4'($urandom_range(0, 15));
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_en"},   64'(ifc.cdb_en_o),       64'd1);
      chk({tag, "_rd"},   64'(ifc.cdb_reg_addr_o), 64'(e.rd));
      chk({tag, "_data"}, 64'(ifc.cdb_data_o),     64'(e.data));
      chk({tag, "_tag"},  64'(ifc.cdb_tag_o),      64'(e.tag));
      chk({tag, "_src"},  64'(ifc.cdb_src_o),      64'(e.src));
    end else begin
      chk({tag, "_en"}, 64'(ifc.cdb_en_o), 64'd0);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    sbq.delete();
    #3;
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pl_rd[i]   = 5'(i + 8);
      pl_data[i] = 32'hA000_0000 + 32'(i);
      pl_tag[i]  = 4'(i + 4);
    end
    reset_i = 1'b0;
    drive(4'b1111, 1'b0);
    #3;
    chk_zero_bus("reset");
    @(negedge clk_i);
    reset_i = 1'b1;

    // Single ALU result.
    pl_rd[0] = 5'd5; pl_data[0] = 32'hDEADBEEF; pl_tag[0] = 4'd3;
    step("alu",      4'b0001, 1'b0, 0);
    step("alu_b",    4'b0000, 1'b0, -1);
    step("alu_idle", 4'b0000, 1'b0, -1);

    // All four valid from reset: 0,1,2,3,0,1,2,3 back-to-back.
    do_reset();
    for (int c = 0; c < 8; c++) step("rr", 4'b1111, 1'b0, c % 4);
    step("rr_drain", 4'b0000, 1'b0, -1);

    // Pointer wrap (LSU with rd=0 is still broadcast).
    pl_rd[1] = 5'd0;
    step("wrap_br",   4'b1000, 1'b0, 3);
    step("wrap_lsu",  4'b1010, 1'b0, 1);
    step("wrap_br2",  4'b1000, 1'b0, 3);
    step("wrap_idle", 4'b0000, 1'b0, -1);

    // Flush while MUL is valid; the ALU broadcast already on the bus stands.
    step("fl_alu",   4'b0001, 1'b0, 0);
    chk("fl_onbus_en", 64'(ifc.cdb_en_o), 64'd1);
    step("fl_mul",   4'b0100, 1'b1, -1);
    step("fl_after", 4'b0100, 1'b0, 2);
    step("fl_idle",  4'b0000, 1'b0, -1);

    // Stall hold: bring pointer to 1, then LSU and MUL contend.
    step("sh_br",  4'b1000, 1'b0, 3);
    step("sh_alu", 4'b0001, 1'b0, 0);
    pl_data[2] = 32'h1234_5678; pl_rd[2] = 5'd17; pl_tag[2] = 4'd9;
    step("sh_lsu",  4'b0110, 1'b0, 1);
    step("sh_mul",  4'b0100, 1'b0, 2);
    step("sh_once", 4'b0000, 1'b0, -1);
    step("sh_none", 4'b0000, 1'b0, -1);

    // Async reset mid-stream (pointer is 3 here).
    step("ar_a", 4'b1111, 1'b0, 3);
    step("ar_b", 4'b1111, 1'b0, 0);
    drive(4'b1111, 1'b0);
    #2;
    reset_i = 1'b0;
    sbq.delete();
    #1;
    chk_zero_bus("areset");
    @(negedge clk_i);
    reset_i = 1'b1;
    step("ar_first",  4'b1111, 1'b0, 0);
    step("ar_second", 4'b1111, 1'b0, 1);
    step("ar_idle",   4'b0000, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
